// File: rtl/halfdup_pkg.sv
// rtl/halfdup_pkg.sv - shared state type, holdoff constant and width helper for the half-duplex link
package halfdup_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_TURN,
        ST_TX,
        ST_REL
    } xcvr_state_e;

    // Cycles to stay quiet after losing a simultaneous request, so the winner's request is seen first.
    localparam int unsigned HOLDOFF_LOSE = 1;

    // Bits needed to hold 0..max_val inclusive.
    function automatic int cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/halfdup_pad.sv
// rtl/halfdup_pad.sv - tristate drivers and receive capture register for the shared bus
module halfdup_pad #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         oe,
    input  logic         tx_stb,
    input  logic [W-1:0] tx_dat,
    input  logic         rx_en,
    inout  wire  [W-1:0] b_dat,
    inout  wire          b_stb,
    output logic         rx_vld,
    output logic [W-1:0] rx_dat
);

    // Pads float whenever output enable is low; oe comes straight from a flop with async clear.
    assign b_dat = oe ? tx_dat : {W{1'bz}};
    assign b_stb = oe ? tx_stb : 1'bz;

    // Capture a peer beat one cycle after its strobe; receive window is gated by the FSM.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_vld <= 1'b0;
            rx_dat <= '0;
        end else begin
            rx_vld <= rx_en & b_stb;
            if (rx_en & b_stb) begin
                rx_dat <= b_dat;
            end
        end
    end

endmodule

// File: rtl/halfdup_xcvr.sv
// rtl/halfdup_xcvr.sv - half-duplex transceiver: bus arbitration, turnaround, burst transmit, receive
module halfdup_xcvr
    import halfdup_pkg::*;
#(
    parameter int W        = 8,
    parameter int TURN     = 2,
    parameter int MAXBURST = 16,
    parameter bit PRIORITY = 1'b0
) (
    input  logic         i_clk,
    input  logic         i_arst_n,
    inout  wire  [W-1:0] b_dat,
    inout  wire          b_stb,
    output logic         o_busReq,
    input  logic         i_busReq,
    input  logic         i_txVld,
    input  logic [W-1:0] i_txData,
    output logic         o_txRdy,
    output logic         o_rxVld,
    output logic [W-1:0] o_rxData,
    output logic         o_busy
);

    localparam int TCW = cnt_w(TURN);
    localparam int BCW = cnt_w(MAXBURST);
    localparam int HCW = cnt_w((TURN > int'(HOLDOFF_LOSE)) ? TURN : int'(HOLDOFF_LOSE));

    xcvr_state_e    state;
    logic           oe;
    logic           stb_q;
    logic [W-1:0]   dat_q;
    logic [TCW-1:0] turn_cnt;
    logic [BCW-1:0] burst_cnt;
    logic [HCW-1:0] hold_cnt;
    logic           beat;
    logic           rx_en;

    assign beat  = o_txRdy & i_txVld;
    // Only listen when we are neither driving nor in a turnaround/release window.
    assign rx_en = (state == ST_IDLE) || (state == ST_REQ);

    // Ownership FSM; every output it produces is a flop so the pads never see decode glitches.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state     <= ST_IDLE;
            oe        <= 1'b0;
            stb_q     <= 1'b0;
            dat_q     <= '0;
            o_busReq  <= 1'b0;
            o_txRdy   <= 1'b0;
            o_busy    <= 1'b0;
            turn_cnt  <= '0;
            burst_cnt <= '0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end else if (i_txVld) begin
                        state    <= ST_REQ;
                        o_busReq <= 1'b1;
                        o_busy   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (!i_busReq) begin
                        state    <= ST_TURN;
                        turn_cnt <= TCW'(TURN);
                    end else if (!PRIORITY) begin
                        state    <= ST_IDLE;
                        o_busReq <= 1'b0;
                        o_busy   <= 1'b0;
                        hold_cnt <= HCW'(HOLDOFF_LOSE);
                    end
                end
                ST_TURN: begin
                    if (turn_cnt == TCW'(1) || turn_cnt == '0) begin
                        turn_cnt  <= '0;
                        state     <= ST_TX;
                        oe        <= 1'b1;
                        o_txRdy   <= 1'b1;
                        burst_cnt <= '0;
                    end else begin
                        turn_cnt <= turn_cnt - 1'b1;
                    end
                end
                ST_TX: begin
                    stb_q <= beat;
                    if (beat) begin
                        dat_q <= i_txData;
                        if (burst_cnt != BCW'(MAXBURST)) begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                        // Last beat of the tenure: stop accepting but keep driving it next cycle.
                        if (burst_cnt == BCW'(MAXBURST - 1)) begin
                            o_txRdy <= 1'b0;
                        end
                    end
                    if (!i_txVld || burst_cnt == BCW'(MAXBURST)) begin
                        state   <= ST_REL;
                        oe      <= 1'b0;
                        o_txRdy <= 1'b0;
                        stb_q   <= 1'b0;
                    end
                end
                ST_REL: begin
                    state    <= ST_IDLE;
                    o_busReq <= 1'b0;
                    o_busy   <= 1'b0;
                    hold_cnt <= HCW'(TURN);
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    halfdup_pad #(.W(W)) u_pad (
        .clk    (i_clk),
        .arst_n (i_arst_n),
        .oe     (oe),
        .tx_stb (stb_q),
        .tx_dat (dat_q),
        .rx_en  (rx_en),
        .b_dat  (b_dat),
        .b_stb  (b_stb),
        .rx_vld (o_rxVld),
        .rx_dat (o_rxData)
    );

endmodule

// File: tb/tb_halfdup_xcvr.sv
// tb/tb_halfdup_xcvr.sv - self-checking bench for halfdup_xcvr
module tb_halfdup_xcvr;

    localparam int N = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tri1 [7:0] bus_dat;
    tri0       bus_stb;
    logic       tx_vld = 1'b0, peer_req = 1'b0, peer_oe = 1'b0, peer_stb = 1'b0;
    logic [7:0] tx_data = 8'h00, peer_dat = 8'h00;
    logic       bus_req, tx_rdy, rx_vld, busy;
    logic [7:0] rx_data;

    assign bus_dat = peer_oe ? peer_dat : 8'bz;
    assign bus_stb = peer_oe ? peer_stb : 1'bz;

    halfdup_xcvr #(.W(8), .TURN(2), .MAXBURST(4), .PRIORITY(1'b0)) u_dut (
        .i_clk(clk), .i_arst_n(rst_n), .b_dat(bus_dat), .b_stb(bus_stb),
        .o_busReq(bus_req), .i_busReq(peer_req), .i_txVld(tx_vld), .i_txData(tx_data),
        .o_txRdy(tx_rdy), .o_rxVld(rx_vld), .o_rxData(rx_data), .o_busy(busy)
    );

    tri1 [7:0] x_dat;
    tri0       x_stb;
    logic       a_req, b_req, a_rdy, b_rdy, a_rxv, b_rxv, a_busy, b_busy;
    logic       a_vld = 1'b0, b_vld = 1'b0;
    logic [7:0] a_dat = 8'h00, b_dat = 8'h00, a_rxd, b_rxd;

    halfdup_xcvr #(.W(8), .TURN(2), .MAXBURST(4), .PRIORITY(1'b0)) u_a (
        .i_clk(clk), .i_arst_n(rst_n), .b_dat(x_dat), .b_stb(x_stb),
        .o_busReq(a_req), .i_busReq(b_req), .i_txVld(a_vld), .i_txData(a_dat),
        .o_txRdy(a_rdy), .o_rxVld(a_rxv), .o_rxData(a_rxd), .o_busy(a_busy)
    );

    halfdup_xcvr #(.W(8), .TURN(2), .MAXBURST(4), .PRIORITY(1'b1)) u_b (
        .i_clk(clk), .i_arst_n(rst_n), .b_dat(x_dat), .b_stb(x_stb),
        .o_busReq(b_req), .i_busReq(a_req), .i_txVld(b_vld), .i_txData(b_dat),
        .o_txRdy(b_rdy), .o_rxVld(b_rxv), .o_rxData(b_rxd), .o_busy(b_busy)
    );

    typedef struct {
        logic       tx_vld;
        logic [7:0] tx_data;
        logic       peer_req;
        logic       peer_oe;
        logic       peer_stb;
        logic [7:0] peer_dat;
        logic       exp_req;
        logic       exp_rdy;
        logic       exp_busy;
        logic       exp_rxv;
        logic [7:0] exp_rxd;
        logic       chk_bdat;
        logic [7:0] exp_bdat;
        logic       exp_bstb;
    } vec_t;

    vec_t vecs[16];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        int sent, seen, cur, gap, order_bad, rx_bad, cyc;
        logic prev_req;
        int tenures[$];
        int gaps[$];
        logic [7:0] a_src[N];
        logic [7:0] b_src[N];
        int a_sent, b_sent, a_n, b_n, bad_ab, bad_ba, contention;
        logic done;

        // single TX, lost tie-break, then peer beats 0x11/0x22/0x33 received
        vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0};
        vecs[1]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0};
        vecs[2]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0};
        vecs[3]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b1};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0};
        vecs[7]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0};
        vecs[8]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0};
        vecs[9]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0};
        vecs[10] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 8'h11, 1'b1};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 8'h22, 1'b1};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 8'h22, 1'b0};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 8'h33, 1'b1};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 1'b1, 8'hFF, 1'b0};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_bdat", bus_dat, 8'hFF);
        chk("rst_bstb", bus_stb, 1'b0);
        chk("rst_req", bus_req, 1'b0);
        chk("rst_rdy", tx_rdy, 1'b0);
        chk("rst_rxv", rx_vld, 1'b0);
        chk("rst_rxd", rx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);

        for (int i = 0; i < 16; i++) begin
            tx_vld = vecs[i].tx_vld;  tx_data = vecs[i].tx_data;  peer_req = vecs[i].peer_req;
            peer_oe = vecs[i].peer_oe; peer_stb = vecs[i].peer_stb; peer_dat = vecs[i].peer_dat;
            @(negedge clk);
            chk($sformatf("row%0d req", i), bus_req, vecs[i].exp_req);
            chk($sformatf("row%0d rdy", i), tx_rdy, vecs[i].exp_rdy);
            chk($sformatf("row%0d busy", i), busy, vecs[i].exp_busy);
            chk($sformatf("row%0d rxv", i), rx_vld, vecs[i].exp_rxv);
            chk($sformatf("row%0d rxd", i), rx_data, vecs[i].exp_rxd);
            chk($sformatf("row%0d bstb", i), bus_stb, vecs[i].exp_bstb);
            if (vecs[i].chk_bdat) chk($sformatf("row%0d bdat", i), bus_dat, vecs[i].exp_bdat);
        end

        // burst limit: 10 beats offered with MAXBURST=4 -> tenures of 4,4,2 separated by fairness gaps
        sent = 0; seen = 0; cur = 0; gap = 0; order_bad = 0; rx_bad = 0; prev_req = bus_req;
        for (cyc = 0; cyc < 400; cyc++) begin
            if (bus_stb === 1'b1) begin
                if (bus_dat !== 8'(8'h40 + seen)) order_bad++;
                seen++;
                cur++;
            end
            if (rx_vld) rx_bad++;
            if (prev_req && !bus_req) begin tenures.push_back(cur); cur = 0; end
            if (!bus_req && sent > 0 && sent < 10) gap++;
            if (!prev_req && bus_req && gap > 0) begin gaps.push_back(gap); gap = 0; end
            prev_req = bus_req;
            if (sent == 10 && seen == 10 && !bus_req && !busy) break;
            if (sent < 10) begin
                tx_vld = 1'b1;
                tx_data = 8'(8'h40 + sent);
                if (tx_rdy) sent++;
            end else begin
                tx_vld = 1'b0;
            end
            @(negedge clk);
        end
        tx_vld = 1'b0;
        chk("burst_timeout", (cyc < 400), 1'b1);
        chk("burst_seen", seen, 10);
        chk("burst_order_bad", order_bad, 0);
        chk("self_rx_pulses", rx_bad, 0);
        chk("tenure_count", tenures.size(), 3);
        if (tenures.size() == 3) begin
            chk("tenure0", tenures[0], 4);
            chk("tenure1", tenures[1], 4);
            chk("tenure2", tenures[2], 2);
        end
        chk("gap_count", gaps.size(), 2);
        if (gaps.size() == 2) begin
            chk("gap0", gaps[0], 3);
            chk("gap1", gaps[1], 3);
        end

        // asynchronous reset while driving a beat
        tx_vld = 1'b1; tx_data = 8'h5A;
        for (int k = 0; k < 20; k++) begin
            if (bus_stb === 1'b1) break;
            @(negedge clk);
        end
        chk("arst_pre_stb", bus_stb, 1'b1);
        chk("arst_pre_dat", bus_dat, 8'h5A);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_bdat", bus_dat, 8'hFF);
        chk("arst_bstb", bus_stb, 1'b0);
        chk("arst_req", bus_req, 1'b0);
        chk("arst_rdy", tx_rdy, 1'b0);
        chk("arst_busy", busy, 1'b0);
        tx_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_rxv", rx_vld, 1'b0);
        chk("arst_rxd", rx_data, 8'h00);

        // two endpoints back to back with random traffic both ways
        for (int i = 0; i < N; i++) begin
            a_src[i] = 8'($urandom);
            b_src[i] = 8'($urandom);
        end
        a_sent = 0; b_sent = 0; a_n = 0; b_n = 0; bad_ab = 0; bad_ba = 0; contention = 0; done = 1'b0;
        for (int c = 0; c < 60000; c++) begin
            if (u_a.oe && u_b.oe) contention++;
            if (b_rxv) begin
                if (b_n >= N || b_rxd !== a_src[b_n]) bad_ab++;
                b_n++;
            end
            if (a_rxv) begin
                if (a_n >= N || a_rxd !== b_src[a_n]) bad_ba++;
                a_n++;
            end
            if (a_sent == N && b_sent == N && a_n == N && b_n == N) begin done = 1'b1; break; end
            if (a_sent < N) begin
                a_vld = ($urandom_range(0, 3) != 0);
                a_dat = a_src[a_sent];
                if (a_vld && a_rdy) a_sent++;
            end else begin
                a_vld = 1'b0;
            end
            if (b_sent < N) begin
                b_vld = ($urandom_range(0, 3) != 0);
                b_dat = b_src[b_sent];
                if (b_vld && b_rdy) b_sent++;
            end else begin
                b_vld = 1'b0;
            end
            @(negedge clk);
        end
        a_vld = 1'b0; b_vld = 1'b0;
        chk("pair_timeout", done, 1'b1);
        chk("pair_contention", contention, 0);
        chk("pair_ab_count", b_n, N);
        chk("pair_ba_count", a_n, N);
        chk("pair_ab_bad", bad_ab, 0);
        chk("pair_ba_bad", bad_ba, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
